spm_host: RTL

Host-side driver for the serial-parallel multiplier (`spm`). It accepts a parallel signed operand pair over a valid/ready handshake and holds `x` on the multiplier's parallel input. It streams `y` LSB-first, sign-extended, into the multiplier's serial input, then deserializes the multiplier's serial product output into a 2·WIDTH-bit result. The block sits between the bus-facing register logic and the `spm` datapath and is the only agent that drives or clears the multiplier.

---
 rtl/spm_host.sv | 117 +++++++++++
 1 files changed

// File: rtl/spm_host.sv
// spm_host: host-side sequencer for the serial-parallel multiplier.
// Holds x on the multiplier's parallel input, streams y LSB-first with sign
// extension for 2*WIDTH bits, and collects the serial product LSB-first
// into a 2*WIDTH-bit result offered on a valid/ready output.
module spm_host #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_x,
  input  logic [WIDTH-1:0]     in_y,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_p,
  output logic                 spm_rst,
  output logic [WIDTH-1:0]     spm_x,
  output logic                 spm_y,
  input  logic                 spm_p
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(PW) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PW - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] ysh_q, ysh_d;
  logic [PW-1:0]   prod_q, prod_d;
  logic            in_ready_q, out_valid_q, spm_rst_q;

  // Next-state, datapath updates and the state-decoded serial operand bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    x_d     = x_q;
    ysh_d   = ysh_q;
    prod_d  = prod_q;
    spm_y   = 1'b0;
    case (state_q)
      S_IDLE: begin
        // in_ready_q already means "in IDLE and out of reset"
        if (in_valid && in_ready_q) begin
          x_d     = in_x;
          ysh_d   = in_y;
          prod_d  = '0;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        spm_y = ysh_q[0];
        // arithmetic shift keeps feeding the sign once y's own bits run out
        ysh_d = {ysh_q[WIDTH-1], ysh_q[WIDTH-1:1]};
        // spm_p lags spm_y by one cycle, so nothing valid arrives at cnt 0
        if (cnt_q != '0) prod_d = {spm_p, prod_q[PW-1:1]};
        if (cnt_q == CNT_LAST) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DRAIN: begin
        spm_y   = ysh_q[WIDTH-1];
        // last product bit (2W-1) produced by the final SHIFT cycle
        prod_d  = {spm_p, prod_q[PW-1:1]};
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, datapath and registered handshake/clear outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      ysh_q       <= '0;
      prod_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      spm_rst_q   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      ysh_q       <= ysh_d;
      prod_q      <= prod_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_DONE);
      spm_rst_q   <= (state_d == S_CLEAR);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_p     = prod_q;
  assign spm_rst   = spm_rst_q;
  assign spm_x     = x_q;

endmodule
